// File: rtl/lms_pkg.sv
// -----------------------------------------------------------------------------
// lms_pkg
// Shared types and helpers for the multi-channel LMS adaptive FIR engine.
//   state_e      : control FSM states (IDLE -> RUN -> DRAIN -> DONE).
//   PIPE_DEPTH   : stages between tap issue and accumulator update.
//   DRAIN_CYCLES : cycles spent flushing the pipeline after the last tap.
//   run_latency  : acceptance-to-done distance in cycles for a given TAPS.
//   sat_dw       : clamps a wide signed value into a dw-bit signed range.
// -----------------------------------------------------------------------------
package lms_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Multiply -> update -> product -> accumulate.
  localparam int unsigned PIPE_DEPTH   = 4;
  localparam int unsigned DRAIN_CYCLES = PIPE_DEPTH - 1;

  // Working width for saturation; must cover 2*DW+2 and the accumulator.
  localparam int SAT_W = 128;

  function automatic int unsigned run_latency(input int unsigned taps);
    return taps + PIPE_DEPTH;
  endfunction

  // Clamp v to [-2^(dw-1), 2^(dw-1)-1]; the caller truncates to dw bits.
  function automatic logic signed [SAT_W-1:0] sat_dw(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// -----------------------------------------------------------------------------
// lms_tap_mac
// Three-stage tap pipeline for the LMS engine. One tap enters per cycle.
//   stage 1 : p = err * x[k]                                 (2*DW bits)
//   stage 2 : w' = adapt ? sat(w + ((p>>>FRAC)>>>mu) - leak) : w
//   stage 3 : prod = w' * x[k]
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_addr    : tap issue strobe and tap index
//   err, x_k, w_k        : latched error, tap sample, current tap weight
//   mu_shift, adapt_en,
//   leak_en              : latched per-run controls (stable during a run)
//   wr_en/wr_addr/wr_data: updated weight write-back (stage 2 result)
//   prod_valid, prod     : w'*x[k] for the accumulator (stage 3 result)
// -----------------------------------------------------------------------------
module lms_tap_mac
  import lms_pkg::*;
#(
  parameter int DW         = 32,
  parameter int FRAC       = 15,
  parameter int LEAK_SHIFT = 10,
  parameter int AW         = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [AW-1:0]          in_addr,
  input  logic signed [DW-1:0]   err,
  input  logic signed [DW-1:0]   x_k,
  input  logic signed [DW-1:0]   w_k,
  input  logic [4:0]             mu_shift,
  input  logic                   adapt_en,
  input  logic                   leak_en,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic signed [DW-1:0]   wr_data,
  output logic                   prod_valid,
  output logic signed [2*DW-1:0] prod
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + 2;

  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [AW-1:0]        addr1_q, addr1_d, addr2_q, addr2_d;
  logic signed [PW-1:0] p1_q, p1_d;
  logic signed [DW-1:0] x1_q, x1_d, w1_q, w1_d;
  logic signed [DW-1:0] wn2_q, wn2_d, x2_q, x2_d;
  logic signed [PW-1:0] prod3_q, prod3_d;

  logic signed [PW-1:0] delta;
  logic signed [PW-1:0] leak;
  logic signed [SW-1:0] sum;

  // NOTE: every signal written here gets a value on every path before any
  // condition, so no latch can be inferred.
  always_comb begin
    v1_d    = in_valid;
    addr1_d = in_addr;
    x1_d    = x_k;
    w1_d    = w_k;
    p1_d    = PW'(err) * PW'(x_k);

    // Two separate arithmetic shifts: truncation toward -inf at each step.
    delta = (p1_q >>> FRAC) >>> mu_shift;
    leak  = '0;
    if (leak_en) leak = PW'(w1_q) >>> LEAK_SHIFT;
    // Two guard bits so w + d - l can never wrap before saturation.
    sum   = SW'(w1_q) + SW'(delta) - SW'(leak);
    wn2_d = adapt_en ? DW'(sat_dw(SAT_W'(sum), DW)) : w1_q;

    v2_d    = v1_q;
    addr2_d = addr1_q;
    x2_d    = x1_q;

    v3_d    = v2_q;
    prod3_d = PW'(wn2_q) * PW'(x2_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  // NOTE: datapath registers are qualified by the valid bits above, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    addr1_q <= addr1_d;
    p1_q    <= p1_d;
    x1_q    <= x1_d;
    w1_q    <= w1_d;
    addr2_q <= addr2_d;
    wn2_q   <= wn2_d;
    x2_q    <= x2_d;
    prod3_q <= prod3_d;
  end

  // A frozen run leaves the stored weight as it is, so no write is needed.
  assign wr_en      = v2_q & adapt_en;
  assign wr_addr    = addr2_q;
  assign wr_data    = wn2_q;
  assign prod_valid = v3_q;
  assign prod       = prod3_q;

endmodule

// File: rtl/lms_fir_mc.sv
// -----------------------------------------------------------------------------
// lms_fir_mc
// Multi-channel LMS adaptive FIR. Each go request processes one channel:
// it shifts x_in into the channel's delay line, walks all taps through
// lms_tap_mac (one tap per cycle), writes the adapted weights back and
// produces sat(acc >>> FRAC) as the filtered output.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   go           : request, accepted only while idle
//   ch_sel       : channel for the request (also target of clr_w)
//   x_in, err_in : new reference sample and error sample
//   mu_shift     : step size 2^-mu_shift
//   adapt_en     : 0 freezes the weights for the run
//   leak_en      : subtract w>>>LEAK_SHIFT on each update
//   clr_w        : zero the weights of ch_sel (idle and go=0 only)
//   busy         : run in progress
//   out_sample   : filtered output, held until the next done
//   out_valid    : one-cycle pulse with a new out_sample
//   done         : one-cycle pulse, coincident with out_valid
// Timing: acceptance is cycle 0, busy on cycles 1..TAPS+4, done on TAPS+4.
// -----------------------------------------------------------------------------
module lms_fir_mc
  import lms_pkg::*;
#(
  parameter int TAPS       = 128,
  parameter int CH         = 2,
  parameter int DW         = 32,
  parameter int FRAC       = 15,
  parameter int LEAK_SHIFT = 10,
  parameter int ACCW       = 2 * DW + $clog2(TAPS),
  localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [CHW-1:0]       ch_sel,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] err_in,
  input  logic [4:0]           mu_shift,
  input  logic                 adapt_en,
  input  logic                 leak_en,
  input  logic                 clr_w,
  output logic                 busy,
  output logic [DW-1:0]        out_sample,
  output logic                 out_valid,
  output logic                 done
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  // The counter indexes taps in RUN and counts drain cycles in DRAIN.
  localparam int CW = (AW > 2) ? AW : 2;
  localparam int PW = 2 * DW;

  // Delay lines and weights, one row per channel.
  logic signed [DW-1:0] x_q [CH][TAPS];
  logic signed [DW-1:0] w_q [CH][TAPS];

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic signed [DW-1:0]   err_q, err_d;
  logic [4:0]             mu_q, mu_d;
  logic                   adapt_q, adapt_d;
  logic                   leak_q, leak_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   out_q, out_d;

  logic                   accept;
  logic                   clear;
  logic                   issue;
  logic [AW-1:0]          tap_addr;

  logic                   mac_wr_en;
  logic [AW-1:0]          mac_wr_addr;
  logic signed [DW-1:0]   mac_wr_data;
  logic                   mac_prod_valid;
  logic signed [PW-1:0]   mac_prod;

  assign accept   = (state_q == S_IDLE) && go;
  assign clear    = (state_q == S_IDLE) && !go && clr_w;
  assign tap_addr = cnt_q[AW-1:0];

  lms_tap_mac #(
    .DW         (DW),
    .FRAC       (FRAC),
    .LEAK_SHIFT (LEAK_SHIFT),
    .AW         (AW)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (issue),
    .in_addr    (tap_addr),
    .err        (err_q),
    .x_k        (x_q[ch_q][tap_addr]),
    .w_k        (w_q[ch_q][tap_addr]),
    .mu_shift   (mu_q),
    .adapt_en   (adapt_q),
    .leak_en    (leak_q),
    .wr_en      (mac_wr_en),
    .wr_addr    (mac_wr_addr),
    .wr_data    (mac_wr_data),
    .prod_valid (mac_prod_valid),
    .prod       (mac_prod)
  );

  // Control FSM: next state, run latches and accumulator.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    err_d   = err_q;
    mu_d    = mu_q;
    adapt_d = adapt_q;
    leak_d  = leak_q;
    acc_d   = acc_q;
    out_d   = out_q;
    issue   = 1'b0;

    if (mac_prod_valid) acc_d = acc_q + ACCW'(mac_prod);

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_RUN;
          cnt_d   = '0;
          ch_d    = ch_sel;
          err_d   = err_in;
          mu_d    = mu_shift;
          adapt_d = adapt_en;
          leak_d  = leak_en;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (cnt_q == CW'(TAPS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Last product lands in acc_d on the final drain cycle.
        if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
          out_d   = DW'(sat_dw(SAT_W'(acc_d >>> FRAC), DW));
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      err_q   <= '0;
      mu_q    <= '0;
      adapt_q <= 1'b0;
      leak_q  <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      mu_q    <= mu_d;
      adapt_q <= adapt_d;
      leak_q  <= leak_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // Sample and weight storage. Clear and write-back never coincide: clear
  // happens only in IDLE, write-back only while a run is in flight.
  // NOTE: these arrays are reset because a reset must leave every delay line
  // and weight at zero; this is what forces flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          x_q[c][k] <= '0;
          w_q[c][k] <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int k = TAPS - 1; k > 0; k--) begin
          x_q[ch_sel][AW'(k)] <= x_q[ch_sel][AW'(k - 1)];
        end
        x_q[ch_sel][0] <= x_in;
      end
      if (clear) begin
        for (int k = 0; k < TAPS; k++) begin
          w_q[ch_sel][AW'(k)] <= '0;
        end
      end else if (mac_wr_en) begin
        w_q[ch_q][mac_wr_addr] <= mac_wr_data;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_valid  = (state_q == S_DONE);
  assign out_sample = out_q;

endmodule

// File: tb/tb_lms_fir_mc.sv
// -----------------------------------------------------------------------------
// tb_lms_fir_mc
// Bench for lms_fir_mc with DW=16, FRAC=8, TAPS=4, CH=2, LEAK_SHIFT=4.
// A table of hand-computed vectors covers reset, adaptation, channel
// isolation, saturation, leakage and weight clear; random runs are compared
// against an arithmetic reference model; hand sequences cover go while busy
// and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_lms_fir_mc;

  localparam int TAPS       = 4;
  localparam int CH         = 2;
  localparam int DW         = 16;
  localparam int FRAC       = 8;
  localparam int LEAK_SHIFT = 4;
  localparam int LAT        = TAPS + 4;
  localparam int WIN        = 20;

  typedef struct {
    bit  rst_b;    // reset before this vector
    bit  clr_b;    // clear the channel's weights before this vector
    bit  ch;
    int  xv;
    int  ev;
    int  mu;
    bit  ad;
    bit  lk;
    int  exp_out;
    int  exp_w0;   // w[ch][0] after the run
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 go = 1'b0;
  logic [0:0]           ch_sel = '0;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] err_in = '0;
  logic [4:0]           mu_shift = '0;
  logic                 adapt_en = 1'b0;
  logic                 leak_en = 1'b0;
  logic                 clr_w = 1'b0;
  logic                 busy;
  logic signed [DW-1:0] out_sample;
  logic                 out_valid;
  logic                 done;

  int vectors = 0;
  int miscompares = 0;

  longint xm [CH][TAPS];
  longint wm [CH][TAPS];

  lms_fir_mc #(
    .TAPS       (TAPS),
    .CH         (CH),
    .DW         (DW),
    .FRAC       (FRAC),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .ch_sel     (ch_sel),
    .x_in       (x_in),
    .err_in     (err_in),
    .mu_shift   (mu_shift),
    .adapt_en   (adapt_en),
    .leak_en    (leak_en),
    .clr_w      (clr_w),
    .busy       (busy),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) begin
        xm[c][k] = 0;
        wm[c][k] = 0;
      end
  endtask

  task automatic model_run(input bit ch, input int xv, input int ev, input int mu,
                           input bit ad, input bit lk, output longint out);
    longint acc, p, d, l;
    for (int k = TAPS - 1; k > 0; k--) xm[ch][k] = xm[ch][k-1];
    xm[ch][0] = xv;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      p = longint'(ev) * xm[ch][k];
      d = (p >>> FRAC) >>> mu;
      l = lk ? (wm[ch][k] >>> LEAK_SHIFT) : 0;
      if (ad) wm[ch][k] = sat16(wm[ch][k] + d - l);
      acc += wm[ch][k] * xm[ch][k];
    end
    out = sat16(acc >>> FRAC);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; go = 1'b0; clr_w = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_ch(input bit ch, input string nm);
    @(negedge clk);
    ch_sel = ch; go = 1'b0; clr_w = 1'b1;
    @(negedge clk);
    clr_w = 1'b0;
    check({nm, " clr busy"}, longint'(busy), 0);
    for (int k = 0; k < TAPS; k++) wm[ch][k] = 0;
  endtask

  // One request; inputs are scrambled after acceptance to prove latching.
  // With spam set, go is held high again on cycles 2..6 of the run.
  task automatic do_run(input string nm, input bit ch, input int xv, input int ev,
                        input int mu, input bit ad, input bit lk, input bit spam,
                        input longint exp_out);
    int     done_cyc, ndone, busy_bad, ov_bad;
    longint got;
    done_cyc = -1; ndone = 0; busy_bad = 0; ov_bad = 0; got = 0;
    @(negedge clk);
    ch_sel = ch; x_in = DW'(xv); err_in = DW'(ev); mu_shift = 5'(mu);
    adapt_en = ad; leak_en = lk; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    x_in = DW'($urandom); err_in = DW'($urandom); mu_shift = 5'($urandom);
    ch_sel = 1'($urandom); adapt_en = 1'($urandom); leak_en = 1'($urandom);
    for (int c = 1; c <= WIN; c++) begin
      if (spam) go = (c >= 2 && c <= 6);
      if (busy !== (c <= LAT)) busy_bad++;
      if (out_valid !== done) ov_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c;
          got = longint'(out_sample);
        end
      end
      @(negedge clk);
    end
    go = 1'b0;
    check({nm, " out"}, got, exp_out);
    check({nm, " done_cycle"}, done_cyc, LAT);
    check({nm, " done_count"}, ndone, 1);
    check({nm, " busy_pattern_errs"}, busy_bad, 0);
    check({nm, " out_valid_vs_done_errs"}, ov_bad, 0);
    check({nm, " out_held"}, longint'(out_sample), exp_out);
  endtask

  initial begin
    vec_t   tbl [11];
    longint want;
    int     nd, nz;

    //           rst   clr   ch    x      err    mu ad    lk    out    w0
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 256,   0,     0, 1'b1, 1'b0, 0,     0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 256,   256,   0, 1'b1, 1'b0, 256,   256};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 256,   0,     0, 1'b0, 1'b0, 256,   256};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 256,   0,     0, 1'b1, 1'b0, 0,     0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 256,   0,     0, 1'b0, 1'b0, 256,   256};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32767, 32767, 0, 1'b1, 1'b0, 32767, 32767};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32767, 32767, 0, 1'b1, 1'b0, 32767, 32767};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32767, 32767, 0, 1'b1, 1'b0, 32767, 32767};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 256,   256,   0, 1'b1, 1'b0, 256,   256};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 256,   0,     0, 1'b1, 1'b1, 240,   240};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 256,   0,     0, 1'b0, 1'b0, 0,     0};

    apply_reset();
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_sample", longint'(out_sample), 0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_b) apply_reset();
      if (tbl[i].clr_b) clear_ch(tbl[i].ch, $sformatf("vec%0d", i));
      model_run(tbl[i].ch, tbl[i].xv, tbl[i].ev, tbl[i].mu, tbl[i].ad, tbl[i].lk, want);
      do_run($sformatf("vec%0d", i), tbl[i].ch, tbl[i].xv, tbl[i].ev, tbl[i].mu,
             tbl[i].ad, tbl[i].lk, 1'b0, longint'(tbl[i].exp_out));
      check($sformatf("vec%0d w0", i), longint'(dut.w_q[tbl[i].ch][0]),
            longint'(tbl[i].exp_w0));
    end

    // go held high while busy: ignored, exactly one done.
    model_run(1'b0, 1000, 300, 2, 1'b1, 1'b0, want);
    do_run("go_while_busy", 1'b0, 1000, 300, 2, 1'b1, 1'b0, 1'b1, want);

    // Randomized runs against the reference model.
    for (int i = 0; i < 30; i++) begin
      bit rc, rad, rlk;
      int rx, re, rmu;
      rc  = 1'($urandom);
      rx  = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom)))
                                        : int'($urandom_range(0, 4000)) - 2000;
      re  = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom)))
                                        : int'($urandom_range(0, 4000)) - 2000;
      rmu = int'($urandom_range(0, 10));
      rad = ($urandom_range(0, 3) != 0);
      rlk = 1'($urandom);
      if ($urandom_range(0, 7) == 0) clear_ch(rc, $sformatf("rand%0d", i));
      model_run(rc, rx, re, rmu, rad, rlk, want);
      do_run($sformatf("rand%0d", i), rc, rx, re, rmu, rad, rlk, (i % 5 == 2), want);
    end

    // Reset on cycle 3 of a run, with nonzero weights beforehand.
    model_run(1'b0, 256, 256, 0, 1'b1, 1'b0, want);
    do_run("pre_abort", 1'b0, 256, 256, 0, 1'b1, 1'b0, 1'b0, want);
    @(negedge clk);
    ch_sel = 1'b0; x_in = 16'sd100; err_in = 16'sd100; mu_shift = 5'd0;
    adapt_en = 1'b1; leak_en = 1'b0; go = 1'b1;      // cycle 0
    @(negedge clk); go = 1'b0;                       // cycle 1
    @(negedge clk);                                  // cycle 2
    @(negedge clk); rst = 1'b1;                      // cycle 3
    @(negedge clk); rst = 1'b0;                      // cycle 4
    model_reset();
    check("abort busy", longint'(busy), 0);
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    check("abort done_count", nd, 0);
    nz = 0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++)
        if (dut.w_q[c][k] != '0) nz++;
    check("abort nonzero_weights", nz, 0);
    check("abort out_sample", longint'(out_sample), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
